float_to_fixed_seq: RTL and testbench

//  Sequential inverse of the 4-bit fixed-to-float normaliser. Consumes a normalised

---
 rtl/float_to_fixed_seq.sv | 121 ++++++++++++
 tb/tb_float_to_fixed_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_seq.sv
// float_to_fixed_seq: sequential inverse of the fixed-to-float normaliser.
// It accepts a normalised mantissa F and a shift count P. It then shifts F
// right one bit per clock to restore D = F >> P, and holds D until it is
// consumed.
// Optional feature macro: FMT_CHECK_EN. When it is defined, the block adds
// the out_err port and the malformed-input checks.
module float_to_fixed_seq #(
    parameter int W  = 4,
    parameter int EW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_f,
    input  logic [EW-1:0] in_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_d
`ifdef FMT_CHECK_EN
    ,output logic         out_err
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_d;
    logic [CW-1:0] w_cnt_ld;
    logic          w_accept;

    // A shift count above W-1 would shift out every bit, so it is clamped.
    // A zero mantissa needs no shifting, so its count is forced to zero.
    // That gives a zero mantissa one clock of latency whatever P is.
    assign w_cnt_ld = ({{(32-EW){1'b0}}, in_p} > 32'(W - 1)) ? CNT_MAX : CW'(in_p);
    assign w_accept = in_valid && (r_state == S_IDLE);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_d     = r_d;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: SHIFT always spends one clock on a zero count before DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)       w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0)    w_next = S_DONE;
            S_DONE:  if (out_ready)      w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift while the count is nonzero.
    // The result register is loaded only on DONE entry, so out_d stays stable
    // while the shift is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_d   <= '0;
        end else begin
            if (w_accept) begin
                r_sh  <= in_f;
                r_cnt <= (in_f == '0) ? '0 : w_cnt_ld;
            end else if (r_state == S_SHIFT) begin
                if (r_cnt != '0) begin
                    r_sh  <= r_sh >> 1;
                    r_cnt <= r_cnt - CW'(1);
                end else begin
                    r_d <= r_sh;
                end
            end
        end
    end

`ifdef FMT_CHECK_EN
    logic r_err_acc;
    logic r_err;

    assign out_err = r_err;

    // Error tracking: flag an unnormalised mantissa at accept, or any set bit
    // lost off the bottom while shifting. The flag is published on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_acc <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err_acc <= (in_f != '0) && !in_f[W-1];
            end else if (r_state == S_SHIFT) begin
                if (r_cnt != '0) begin
                    r_err_acc <= r_err_acc | r_sh[0];
                end else begin
                    r_err <= r_err_acc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Directed bench for float_to_fixed_seq: known F/P vectors with hand-computed
// results, latency, backpressure, and reset abort.
module tb_float_to_fixed_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_f;
    logic [1:0] in_p;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_d;
`ifdef FMT_CHECK_EN
    logic       out_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    float_to_fixed_seq #(.W(4), .EW(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d)
`ifdef FMT_CHECK_EN
        ,.out_err  (out_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present a pair and let it be accepted on the next rising edge.
    task automatic start_op(input string tag, input logic [3:0] f, input logic [1:0] p);
        @(negedge clk);
        in_f     = f;
        in_p     = p;
        in_valid = 1'b1;
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_f     = ~f;
        in_p     = ~p;
    endtask

    // Count edges from the accept edge until out_valid rises; bounded.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ovld_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [1:0] p,
                          input logic [3:0] exp_d, input int exp_lat, input logic exp_err);
        start_op(tag, f, p);
        wait_done(tag, exp_lat);
        check({tag, "_d"}, 32'(out_d), 32'(exp_d));
`ifdef FMT_CHECK_EN
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
`else
        if (exp_err) begin end
`endif
        finish_op(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_f      = 4'd0;
        in_p      = 2'd0;
        #2;
        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_d", 32'(out_d), 32'd0);
`ifdef FMT_CHECK_EN
        check("rst_err", 32'(out_err), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1",  4'b1010, 2'b01, 4'b0101, 2, 1'b0);
        run_op("t2a", 4'b1000, 2'b11, 4'b0001, 4, 1'b0);
        run_op("t2b", 4'b1100, 2'b00, 4'b1100, 1, 1'b0);
        run_op("t3",  4'b0000, 2'b10, 4'b0000, 1, 1'b0);

        // Backpressure: result held, no accept while DONE.
        start_op("bp", 4'b1010, 2'b01);
        wait_done("bp", 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_f     = 4'b1111;
            in_p     = 2'b00;
            @(posedge clk);
            #1;
            check("bp_ovld_hold", 32'(out_valid), 32'd1);
            check("bp_inrdy_low", 32'(in_ready), 32'd0);
            check("bp_d_hold", 32'(out_d), 32'(4'b0101));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_ovld_clr", 32'(out_valid), 32'd0);
        check("bp_inrdy_back", 32'(in_ready), 32'd1);
        check("bp_d_kept", 32'(out_d), 32'(4'b0101));
        @(posedge clk);
        #1;
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset during SHIFT aborts immediately.
        start_op("rs", 4'b1000, 2'b11);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rs_d_stable_shift", 32'(out_d), 32'(4'b0101));
        check("rs_inrdy_shift", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rs_ovld", 32'(out_valid), 32'd0);
        check("rs_inrdy", 32'(in_ready), 32'd1);
        check("rs_d", 32'(out_d), 32'd0);
        in_valid = 1'b1;
        in_f     = 4'b1111;
        in_p     = 2'b11;
        @(posedge clk);
        #1;
        check("rs_ignore_inrdy", 32'(in_ready), 32'd1);
        check("rs_ignore_ovld", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        run_op("t5", 4'b1110, 2'b01, 4'b0111, 2, 1'b0);

        run_op("t6a", 4'b0110, 2'b01, 4'b0011, 2, 1'b1);
        run_op("t6b", 4'b1001, 2'b10, 4'b0010, 3, 1'b1);
        run_op("t6c", 4'b1010, 2'b01, 4'b0101, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
